bios_loader: RTL and testbench
==============================

// Module: bios_loader
// PURPOSE
//  Sequences a BIOS image from the data_io byte stream (ioctl_*) into the Next186 system BIOS write port.
//  Packs bytes little-endian into 16-bit words and stages them in two ping-pong banks of BURST_WORDS words.
//  Each full bank is offered to the system as a burst (bios_wr/bios_req handshake).
//  Raises bios_loaded once the whole image has been drained; the top-level CPU reset is held until then.
// PARAMETERS
//  BURST_WORDS  32   words per bank; power of 2, 2..256; two banks are instantiated
//  ROM_INDEX    8'd0 ioctl_index value accepted; a download with any other index is ignored entirely
//  ADDR_W       13   width of the word address bios_addr; the image limit is 2^ADDR_W words
// PORTS
//  clk_sys        in   1   single clock (SDRAM clock domain at top level)
//  reset_n        in   1   asynchronous, active-low reset
//  ioctl_download in   1   download-active level from data_io
//  ioctl_index    in   8   download slot index
//  ioctl_wr       in   1   one-cycle byte strobe
//  ioctl_addr     in   25  byte address of ioctl_dout
//  ioctl_dout     in   8   byte data
//  bios_wr        out  1   a full bank is pending; system may pull words
//  bios_req       in   1   system pull, one word per cycle it is high while bios_wr=1
//  bios_addr      out  ADDR_W  word address of bios_din
//  bios_din       out  16  word data
//  bios_loaded    out  1   image fully delivered (sticky until next accepted download)
//  overrun        out  1   sticky; a byte was dropped (both banks full or address >= limit)
//  checksum       out  8   byte sum of accepted bytes (macro-dependent)
// BEHAVIOUR
//  Reset values: bios_wr=0, bios_addr=0, bios_din=0, bios_loaded=0, overrun=0, checksum=0; FSM=IDLE.
//  Pointers, banks-pending count and byte latch all clear.
//  Download start: rising ioctl_download with ioctl_index==ROM_INDEX -> FILL.
//    Clears bios_loaded, overrun, checksum and all pointers.
//  Byte packing in FILL:
//    Even address latches the low byte.
//    Odd address writes {ioctl_dout, low} into bank word (ioctl_addr[1+:log2(2*BURST_WORDS)]).
//    The word written on bank index BURST_WORDS-1 marks that bank full (pending +1).
//  Drop rule: byte dropped and overrun=1 when ioctl_addr >= 2*2^ADDR_W.
//    Also dropped when the target bank is still pending (both banks full).
//  Drain: bios_wr = (pending != 0).
//    Each cycle bios_req & bios_wr: next clk updates bios_din <= bank[rd_ptr] and bios_addr <= word counter.
//    The first word of a download appears with bios_addr=0. Latency: 1 clk req->data.
//    After BURST_WORDS pulls the bank is released (pending -1).
//    bios_req while bios_wr=0 is ignored.
//  Same-cycle bank-full and bank-release: pending unchanged.
//  bios_addr wraps modulo 2^ADDR_W; unreachable because of the drop rule.
//  End of download (falling ioctl_download) -> FLUSH.
//    A partially filled bank is padded with 16'hFFFF to BURST_WORDS and marked full.
//    A dangling odd byte becomes {8'hFF, low}. An empty bank is not flushed.
//  FLUSH -> DRAIN -> DONE when pending==0. Entering DONE sets bios_loaded=1.
//  A new matching download rising edge in any state restarts from FILL (pending banks discarded).
//  Reset mid-operation returns to IDLE with reset values; no partial image is ever flagged loaded.
// CONFIGURATION
//  BIOS_LOADER_CHECKSUM_EN defined:
//    checksum accumulates (mod 256) every accepted byte, pad bytes excluded.
//    Final value is stable in DONE; 8'h00 means a valid option-ROM style image.
//  Undefined: checksum tied to 8'h00, no adder.
// STRUCTURE
//  next186_pkg: loader_state_t enum {IDLE, FILL, FLUSH, DRAIN, DONE}; BIOS_PAD_WORD=16'hFFFF.
//  Sub-module bios_loader_buf: 2*BURST_WORDS x 16 simple dual-port RAM, 1 write port, registered read.
// TESTING
//  1. 128-byte image, bytes=i, req high continuously once bios_wr=1 ->
//     64 words at addr 0..63, word0=16'h0100; bios_loaded=1 after last word.
//  2. 130 bytes -> words 64 = 16'h8180, words 65..95 = 16'hFFFF; 96 words delivered.
//  3. req held low, 200 bytes streamed -> bios_wr=1; bytes 128..199 dropped; overrun=1.
//  4. ioctl_index=8'd1 download -> no bios_wr, bios_loaded stays 0.
//  5. reset_n low mid-drain at word 40 -> all outputs at reset values next edge.
//     A new 64-byte download then delivers from addr 0.
//  6. CHECKSUM_EN, 64 bytes summing to 8'h00 -> checksum=8'h00 in DONE;
//     corrupt 1 byte by +1 -> 8'h01.

Source files
------------

// File: rtl/next186_pkg.sv
// Shared types and constants for the Next186 BIOS loader.
//   loader_state_t : loader sequencing states
//   BIOS_PAD_WORD  : fill word for the unused tail of the last bank
//   BIOS_PAD_BYTE  : high byte that completes a dangling odd byte
package next186_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    DRAIN,
    DONE
  } loader_state_t;

  localparam logic [15:0] BIOS_PAD_WORD = 16'hFFFF;
  localparam logic [7:0]  BIOS_PAD_BYTE = 8'hFF;

endpackage

// File: rtl/bios_loader_buf.sv
// Ping-pong staging buffer for the BIOS loader: simple dual-port RAM,
// one write port, one registered read port.
//   clk_i   : clock
//   rst_n_i : async active-low reset (clears the read register only)
//   we_i    : write enable
//   waddr_i : write word address
//   wdata_i : write word
//   re_i    : read enable; rdata_o updates on the next edge
//   raddr_i : read word address
//   rdata_o : registered read word
module bios_loader_buf #(
  parameter int unsigned AW = 6
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bios_loader.sv
// BIOS loader: packs the data_io byte stream into 16-bit little-endian
// words, stages them in two ping-pong banks and offers each full bank to
// the system BIOS write port as a burst. bios_loaded rises once the whole
// image has been drained.
// Optional feature: define BIOS_LOADER_CHECKSUM_EN to accumulate a mod-256
// byte sum of accepted bytes on checksum; otherwise checksum is 8'h00.
// Ports:
//   clk_sys, reset_n            : clock, async active-low reset
//   ioctl_download/index/wr/addr/dout : data_io download stream
//   bios_wr  (out) : a full bank is pending
//   bios_req (in)  : pull one word per cycle while bios_wr
//   bios_addr/bios_din (out) : word address / data, 1 clk after pull
//   bios_loaded (out) : image fully delivered
//   overrun (out)  : sticky, a byte was dropped
//   checksum (out) : byte sum of accepted bytes
module bios_loader
  import next186_pkg::*;
#(
  parameter int unsigned BURST_WORDS = 32,
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter int unsigned ADDR_W      = 13
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              bios_wr,
  input  logic              bios_req,
  output logic [ADDR_W-1:0] bios_addr,
  output logic [15:0]       bios_din,
  output logic              bios_loaded,
  output logic              overrun,
  output logic [7:0]        checksum
);

  localparam int unsigned BIDX_W = $clog2(BURST_WORDS);
  localparam int unsigned IDX_W  = BIDX_W + 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BURST_WORDS - 1);
  // Byte-address limit: 2 bytes per word, 2^ADDR_W words.
  localparam logic [25:0] BYTE_LIMIT = 26'(1) << (ADDR_W + 1);

  loader_state_t state_q, state_d;

  logic              dl_q;
  logic [1:0]        bank_full_q, bank_full_d;
  logic              rd_bank_q;
  logic [BIDX_W-1:0] rd_idx_q;
  logic [ADDR_W-1:0] word_cnt_q;
  logic [ADDR_W-1:0] bios_addr_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic [7:0]        low_q;
  logic              have_low_q;
  logic              overrun_q;

  logic              dl_rise, dl_fall, start;
  logic [IDX_W-1:0]  tgt_idx;
  logic              tgt_bank, tgt_last, addr_over;
  logic              byte_in, drop, accept, fill_we;
  logic              flush_need, pad_we;
  logic              pull, release_bank;
  logic              mark_en, mark_bank;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [15:0]       ram_wdata;

  // ---------------- datapath control ----------------
  always_comb begin
    dl_rise   = ioctl_download & ~dl_q;
    dl_fall   = ~ioctl_download & dl_q;
    start     = dl_rise && (ioctl_index == ROM_INDEX);

    tgt_idx   = ioctl_addr[1 +: IDX_W];
    tgt_bank  = tgt_idx[IDX_W-1];
    tgt_last  = (tgt_idx[BIDX_W-1:0] == LAST_IDX);
    addr_over = ({1'b0, ioctl_addr} >= BYTE_LIMIT);

    byte_in   = (state_q == FILL) && ioctl_wr && !start;
    drop      = addr_over || bank_full_q[tgt_bank];
    accept    = byte_in && !drop;
    fill_we   = accept && ioctl_addr[0];

    // Pad only a bank that holds data: a dangling low byte or a
    // non-zero in-bank write index means the bank is partially filled.
    flush_need = have_low_q || (wr_idx_q[BIDX_W-1:0] != '0);
    pad_we     = (state_q == FLUSH) && flush_need;

    pull         = bios_req && (bank_full_q != '0) && !start;
    release_bank = pull && (rd_idx_q == LAST_IDX);

    mark_en   = 1'b0;
    mark_bank = 1'b0;
    if (fill_we && tgt_last) begin
      mark_en   = 1'b1;
      mark_bank = tgt_bank;
    end else if (pad_we && (wr_idx_q[BIDX_W-1:0] == LAST_IDX)) begin
      mark_en   = 1'b1;
      mark_bank = wr_idx_q[IDX_W-1];
    end

    // A bank being released is full and a bank being marked is not,
    // so both updates never target the same bit.
    bank_full_d = bank_full_q;
    if (start) begin
      bank_full_d = '0;
    end else begin
      if (release_bank) bank_full_d[rd_bank_q] = 1'b0;
      if (mark_en)      bank_full_d[mark_bank] = 1'b1;
    end

    ram_we    = fill_we || pad_we;
    ram_waddr = pad_we ? wr_idx_q : tgt_idx;
    if (pad_we) ram_wdata = have_low_q ? {BIOS_PAD_BYTE, low_q} : BIOS_PAD_WORD;
    else        ram_wdata = {ioctl_dout, low_q};
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      bank_full_q <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      word_cnt_q  <= '0;
      bios_addr_q <= '0;
      wr_idx_q    <= '0;
      low_q       <= '0;
      have_low_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dl_q        <= ioctl_download;
      bank_full_q <= bank_full_d;
      if (start) begin
        rd_bank_q  <= 1'b0;
        rd_idx_q   <= '0;
        word_cnt_q <= '0;
        wr_idx_q   <= '0;
        low_q      <= '0;
        have_low_q <= 1'b0;
        overrun_q  <= 1'b0;
      end else begin
        if (pull) begin
          rd_idx_q    <= rd_idx_q + BIDX_W'(1);
          word_cnt_q  <= word_cnt_q + ADDR_W'(1);
          bios_addr_q <= word_cnt_q;
          if (release_bank) rd_bank_q <= ~rd_bank_q;
        end
        if (byte_in && drop) overrun_q <= 1'b1;
        if (accept) begin
          if (!ioctl_addr[0]) begin
            low_q      <= ioctl_dout;
            have_low_q <= 1'b1;
            wr_idx_q   <= tgt_idx;
          end else begin
            have_low_q <= 1'b0;
            wr_idx_q   <= tgt_idx + IDX_W'(1);
          end
        end
        if (pad_we) begin
          wr_idx_q   <= wr_idx_q + IDX_W'(1);
          have_low_q <= 1'b0;
        end
      end
    end
  end

  bios_loader_buf #(
    .AW (IDX_W)
  ) u_buf (
    .clk_i   (clk_sys),
    .rst_n_i (reset_n),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (pull),
    .raddr_i ({rd_bank_q, rd_idx_q}),
    .rdata_o (bios_din)
  );

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [7:0] ck_q;
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)    ck_q <= '0;
    else if (start)  ck_q <= '0;
    else if (accept) ck_q <= ck_q + ioctl_dout;
  end
  assign checksum = ck_q;
`else
  assign checksum = '0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (dl_fall) state_d = FLUSH;
        FLUSH:   if (!flush_need) state_d = DRAIN;
        DRAIN:   if (bank_full_q == '0) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bios_wr     = (bank_full_q != '0);
    bios_loaded = (state_q == DONE);
    bios_addr   = bios_addr_q;
    overrun     = overrun_q;
  end

endmodule

// File: tb/tb_bios_loader.sv
module tb_bios_loader;

  localparam int unsigned BW     = 32;
  localparam int unsigned AW     = 13;
  localparam int unsigned LIMIT  = 2 * (1 << AW);

  logic          clk_sys = 1'b0;
  logic          reset_n = 1'b0;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = '0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          bios_wr;
  logic          bios_req = 1'b0;
  logic [AW-1:0] bios_addr;
  logic [15:0]   bios_din;
  logic          bios_loaded;
  logic          overrun;
  logic [7:0]    checksum;

  bios_loader #(
    .BURST_WORDS (BW),
    .ROM_INDEX   (8'd0),
    .ADDR_W      (AW)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .bios_wr        (bios_wr),
    .bios_req       (bios_req),
    .bios_addr      (bios_addr),
    .bios_din       (bios_din),
    .bios_loaded    (bios_loaded),
    .overrun        (overrun),
    .checksum       (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  img [512];
  logic [31:0] exp_q [$];
  int          delivered = 0;
  int          req_mode = 0;   // 0 low, 1 high, 2 random
  bit          pulled = 1'b0;
  bit          wr_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // System-side puller and word scoreboard: a pull seen before a rising
  // edge yields {addr,data} to compare on the following falling edge.
  always @(negedge clk_sys) begin
    logic [31:0] got, expw;
    bit nreq;
    if (pulled && reset_n) begin
      delivered++;
      got  = {16'(bios_addr), bios_din};
      expw = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("word", got, expw);
    end
    if (bios_wr) wr_seen = 1'b1;
    case (req_mode)
      1:       nreq = 1'b1;
      2:       nreq = ($urandom_range(0, 3) != 0);
      default: nreq = 1'b0;
    endcase
    bios_req = nreq;
    pulled   = nreq && bios_wr && reset_n;
  end

  // Reference image: little-endian words, 0xFF for missing bytes, image
  // rounded up to whole bursts; addresses count from 0.
  task automatic expect_image(input int n);
    int nw, total;
    logic [7:0] lo, hi;
    exp_q.delete();
    nw    = (n + 1) / 2;
    total = ((nw + int'(BW) - 1) / int'(BW)) * int'(BW);
    for (int k = 0; k < total; k++) begin
      lo = (2*k     < n) ? img[2*k]     : 8'hFF;
      hi = (2*k + 1 < n) ? img[2*k + 1] : 8'hFF;
      exp_q.push_back({16'(k), hi, lo});
    end
  endtask

  function automatic logic [7:0] exp_ck(input int n);
    logic [7:0] s = '0;
`ifdef BIOS_LOADER_CHECKSUM_EN
    for (int i = 0; i < n; i++) s = s + img[i];
`else
    s = 8'(n * 0);
`endif
    return s;
  endfunction

  task automatic do_reset();
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    req_mode       = 0;
    repeat (3) @(negedge clk_sys);
    exp_q.delete();
    reset_n   = 1'b1;
    @(negedge clk_sys);
    delivered = 0;
    wr_seen   = 1'b0;
  endtask

  task automatic stream(input int n, input logic [7:0] idx);
    ioctl_index = idx;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < n; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = img[i];
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
      repeat (3) @(negedge clk_sys);
    end
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic wait_loaded(input string name);
    int c = 0;
    while (!bios_loaded && c < 20000) begin
      @(negedge clk_sys);
      c++;
    end
    check(name, 32'(bios_loaded), 32'd1);
  endtask

  typedef struct {
    int         n;
    logic [7:0] idx;
    int         exp_words;
    bit         exp_loaded;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n, c;
    logic [7:0] s;

    vecs[0] = '{128, 8'd0, 64, 1'b1};
    vecs[1] = '{130, 8'd0, 96, 1'b1};
    vecs[2] = '{1,   8'd0, 32, 1'b1};
    vecs[3] = '{0,   8'd0, 0,  1'b1};
    vecs[4] = '{64,  8'd1, 0,  1'b0};
    vecs[5] = '{62,  8'd0, 32, 1'b1};

    for (int i = 0; i < 512; i++) img[i] = 8'(i);

    // Reset state
    repeat (2) @(negedge clk_sys);
    check("rst_wr",       32'(bios_wr),     32'd0);
    check("rst_addr",     32'(bios_addr),   32'd0);
    check("rst_din",      32'(bios_din),    32'd0);
    check("rst_loaded",   32'(bios_loaded), 32'd0);
    check("rst_overrun",  32'(overrun),     32'd0);
    check("rst_checksum", 32'(checksum),    32'd0);

    // Table-driven downloads, system pulling continuously
    for (int v = 0; v < 6; v++) begin
      do_reset();
      if (vecs[v].idx == 8'd0) expect_image(vecs[v].n);
      req_mode = 1;
      stream(vecs[v].n, vecs[v].idx);
      if (vecs[v].exp_loaded) wait_loaded("vec_loaded");
      else begin
        repeat (200) @(negedge clk_sys);
        check("vec_not_loaded", 32'(bios_loaded), 32'd0);
      end
      repeat (3) @(negedge clk_sys);
      check("vec_words",    32'(delivered),    32'(vecs[v].exp_words));
      check("vec_leftover", 32'(exp_q.size()), 32'd0);
      check("vec_wr_seen",  32'(wr_seen),      32'(vecs[v].exp_words != 0));
      check("vec_overrun",  32'(overrun),      32'd0);
      check("vec_checksum", 32'(checksum),     32'(exp_ck(vecs[v].idx == 8'd0 ? vecs[v].n : 0)));
    end

    // Both banks full with no pulls: bytes 128..199 are dropped
    do_reset();
    stream(200, 8'd0);
    check("ovr_wr",      32'(bios_wr), 32'd1);
    check("ovr_overrun", 32'(overrun), 32'd1);
    expect_image(128);
    req_mode = 1;
    wait_loaded("ovr_loaded");
    repeat (3) @(negedge clk_sys);
    check("ovr_words",    32'(delivered),    32'd64);
    check("ovr_leftover", 32'(exp_q.size()), 32'd0);
    check("ovr_checksum", 32'(checksum),     32'(exp_ck(128)));

    // Address limit: last legal byte accepted, next one dropped
    do_reset();
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    ioctl_addr = 25'(LIMIT - 1); ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
    @(negedge clk_sys); ioctl_wr = 1'b0; @(negedge clk_sys);
    check("lim_ok_overrun", 32'(overrun), 32'd0);
    check("lim_bank_full",  32'(bios_wr), 32'd1);
    ioctl_addr = 25'(LIMIT); ioctl_wr = 1'b1;
    @(negedge clk_sys); ioctl_wr = 1'b0; @(negedge clk_sys);
    check("lim_overrun", 32'(overrun), 32'd1);

    // Reset in the middle of draining, then a fresh download
    do_reset();
    expect_image(128);
    req_mode = 1;
    stream(128, 8'd0);
    c = 0;
    while (delivered < 40 && c < 5000) begin
      @(negedge clk_sys);
      c++;
    end
    check("mid_reached40", 32'(delivered >= 40), 32'd1);
    reset_n = 1'b0;
    @(posedge clk_sys); #1;
    check("mid_wr",       32'(bios_wr),     32'd0);
    check("mid_addr",     32'(bios_addr),   32'd0);
    check("mid_din",      32'(bios_din),    32'd0);
    check("mid_loaded",   32'(bios_loaded), 32'd0);
    check("mid_overrun",  32'(overrun),     32'd0);
    check("mid_checksum", 32'(checksum),    32'd0);
    do_reset();
    expect_image(64);
    req_mode = 1;
    stream(64, 8'd0);
    wait_loaded("mid_reload");
    repeat (3) @(negedge clk_sys);
    check("mid_words",    32'(delivered),    32'd32);
    check("mid_leftover", 32'(exp_q.size()), 32'd0);

    // Checksum of an image summing to zero, then one byte corrupted by +1
    s = '0;
    for (int i = 0; i < 63; i++) begin
      img[i] = 8'($urandom);
      s = s + img[i];
    end
    img[63] = 8'(0) - s;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) img[5] = img[5] + 8'd1;
      expect_image(64);
      delivered = 0;
      stream(64, 8'd0);
      wait_loaded("ck_loaded");
      repeat (3) @(negedge clk_sys);
`ifdef BIOS_LOADER_CHECKSUM_EN
      check("ck_value", 32'(checksum), (pass == 0) ? 32'h00 : 32'h01);
`else
      check("ck_value", 32'(checksum), 32'h00);
`endif
      check("ck_leftover", 32'(exp_q.size()), 32'd0);
    end

    // Randomized images with random system pulls, back to back
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 300);
      for (int i = 0; i < n; i++) img[i] = 8'($urandom);
      expect_image(n);
      delivered = 0;
      req_mode  = 2;
      stream(n, 8'd0);
      wait_loaded("rnd_loaded");
      repeat (3) @(negedge clk_sys);
      check("rnd_words",    32'(delivered),    32'((((n + 1) / 2 + int'(BW) - 1) / int'(BW)) * int'(BW)));
      check("rnd_leftover", 32'(exp_q.size()), 32'd0);
      check("rnd_overrun",  32'(overrun),      32'd0);
      check("rnd_checksum", 32'(checksum),     32'(exp_ck(n)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
